mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Clocked controller that shares the 64x64 asynchronous memory (DataBus inout, MemWr, MemRd, Addr)
//  between two requesters. Each requester uses a valid/ready handshake and gets a one-cycle response.
//  The controller sequences setup/strobe/hold phases, so MemRd and MemWr are never high together.
//  It drives DataBus only during its own write phases. Sits between the client logic and the memory instance.
// PARAMETERS
//  ADDR_W     6   memory address width (64 words)
//  DATA_W     64  memory word width
//  STROBE_CYC 1   cycles MemRd/MemWr are held high per access (>=1)
// PORTS
//  clk        in     1        single clock, rising edge
//  rst_n      in     1        asynchronous, active-low reset
//  req_valid  in     2        per-requester request valid
//  req_ready  out    2        per-requester accept (one-hot or 0)
//  req_wr     in     2        1=write, 0=read, per requester
//  req_addr   in     2*ADDR_W per-requester address, [ADDR_W-1:0] is requester 0
//  req_wdata  in     2*DATA_W per-requester write data
//  rsp_valid  out    2        one-cycle completion pulse to the owning requester
//  rsp_rdata  out    DATA_W   read data, valid with rsp_valid (0 for writes)
//  rsp_err    out    1        read-back mismatch, valid with rsp_valid (macro only, else 0)
//  mem_wr     out    1        memory MemWr
//  mem_rd     out    1        memory MemRd
//  mem_addr   out    ADDR_W   memory Addr
//  mem_data   inout  DATA_W   memory DataBus
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr=0, mem_rd=0, mem_addr=0,
//    mem_data=Z, state=IDLE, rr_ptr=0.
//  FSM states:
//    IDLE  : req_ready goes high combinationally for the granted requester only.
//            On valid&ready, latch wr/addr/wdata/owner, then go to SETUP.
//    SETUP : address driven, both strobes low; write data driven if write. 1 cycle, then STROBE.
//    STROBE: mem_rd or mem_wr high for STROBE_CYC cycles (counter).
//            Read data registered on the last strobe cycle.
//    HOLD  : strobes low; address and write data held. rsp_valid[owner]=1. Next state IDLE.
//  Latency: handshake in cycle 0 -> rsp_valid in cycle 2+STROBE_CYC. Max 1 access per 3+STROBE_CYC cycles.
//  Arbitration: round-robin. With both valid, requester rr_ptr wins; rr_ptr then points to the loser.
//    A lone requester always wins; rr_ptr updates only on a grant.
//  req_ready is 0 outside IDLE. Requests stay pending while valid is held; no reordering, no queueing.
//  mem_data is driven only while the latched op is a write in SETUP/STROBE/HOLD, otherwise Z.
//  Outputs are registered except req_ready.
//  Reset mid-access: strobes drop and the bus tristates immediately; the in-flight op is lost with no rsp_valid.
//  STROBE_CYC=0 is illegal and is flagged by an elaboration check.
// CONFIGURATION
//  MEM_CTRL_RDBACK_EN defined:
//    Each write is followed by RB_SETUP -> RB_STROBE (mem_rd) states, and rsp_valid moves to RB_HOLD.
//    Read data is compared to wdata; rsp_err=1 on mismatch. Write latency grows by 2+STROBE_CYC.
//  Not defined: no RB_* states and rsp_err is tied 0.
// STRUCTURE
//  mem_ctrl_pkg holds: state_e enum (IDLE, SETUP, STROBE, HOLD, RB_SETUP, RB_STROBE, RB_HOLD),
//    ADDR_W/DATA_W defaults, and a req_t struct {wr, addr, wdata, owner}.
//  Sub-module rr_arb2: 2-way round-robin arbiter (valid[1:0], advance -> grant[1:0], holds rr_ptr).
// TESTING
//  1. Reset, then idle: all outputs match reset values; mem_data=Z; no strobes.
//  2. Req0 writes addr 6'h05, data 64'hDEAD_BEEF_0123_4567, then reads it back.
//     Expect mem_wr pulse of STROBE_CYC cycles, then rsp_rdata=64'hDEAD_BEEF_0123_4567.
//  3. Both requesters valid: req0 reads 6'h00, req1 reads 6'h3F.
//     Expect grant order 0,1,0,1 and each rsp_valid pulse only on the owning bit.
//  4. rst_n pulled low in the STROBE cycle of a write: mem_wr drops asynchronously, bus goes Z, no rsp_valid.
//     After release, the same request is re-served.
//  5. STROBE_CYC=3: read latency is 5 cycles. Checker confirms mem_rd&mem_wr is never 1 and there is no bus drive during reads.
//  6. With MEM_CTRL_RDBACK_EN and the memory model forced to corrupt addr 6'h10: write there gives rsp_err=1.
//     Writes to other addresses give rsp_err=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the two-requester asynchronous-memory access controller.
// State list includes the read-back states used when MEM_CTRL_RDBACK_EN is defined.
package mem_ctrl_pkg;

  localparam int unsigned MemAddrW = 6;
  localparam int unsigned MemDataW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRbSetup,
    StRbStrobe,
    StRbHold
  } state_e;

  typedef struct packed {
    logic                wr;
    logic [MemAddrW-1:0] addr;
    logic [MemDataW-1:0] wdata;
    logic                owner;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser on each grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q;

  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o[rr_ptr_q] = 1'b1;
    end else begin
      grant_o = valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= 1'b0;
    end else if (advance_i && (valid_i != 2'b00)) begin
      // Point at whichever requester did not win this round.
      rr_ptr_q <= ~grant_o[1];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one asynchronous memory between two valid/ready requesters with setup/strobe/hold
// sequencing. Define MEM_CTRL_RDBACK_EN to verify every write with a read-back (rsp_err_o).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = MemAddrW,
  parameter int unsigned DATA_W     = MemDataW,
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [1:0]          req_wr_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic [1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                mem_wr_o,
  output logic                mem_rd_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  inout  wire  [DATA_W-1:0]   mem_data_io
);

  if (STROBE_CYC < 1) begin : g_bad_strobe
    $error("STROBE_CYC must be at least 1");
  end
  if ((ADDR_W != MemAddrW) || (DATA_W != MemDataW)) begin : g_bad_width
    $error("ADDR_W/DATA_W must match the req_t field widths in mem_ctrl_pkg");
  end

  localparam int unsigned CntW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STROBE_CYC - 1);

  state_e          state_q;
  req_t            req_q;
  req_t            sel_req;
  logic [CntW-1:0] cnt_q;
  logic            drive_q;
  logic [1:0]      grant;
  logic            accept;
  logic            gnt_idx;

  assign accept  = (state_q == StIdle) && (req_valid_i != 2'b00);
  assign gnt_idx = grant[1];

  // Reset gating keeps req_ready_o low while rst_ni is asserted even with valid held.
  assign req_ready_o = (rst_ni && (state_q == StIdle)) ? grant : 2'b00;

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (req_valid_i),
    .advance_i (accept),
    .grant_o   (grant)
  );

  always_comb begin
    sel_req.wr    = gnt_idx ? req_wr_i[1] : req_wr_i[0];
    sel_req.addr  = gnt_idx ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    sel_req.wdata = gnt_idx ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
    sel_req.owner = gnt_idx;
  end

  assign mem_data_io = drive_q ? req_q.wdata : {DATA_W{1'bz}};

`ifdef MEM_CTRL_RDBACK_EN
  logic rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      req_q       <= '0;
      cnt_q       <= '0;
      drive_q     <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_rd_o    <= 1'b0;
      mem_addr_o  <= '0;
      rsp_valid_o <= 2'b00;
      rsp_rdata_o <= '0;
`ifdef MEM_CTRL_RDBACK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= 2'b00;
      rsp_rdata_o <= '0;
`ifdef MEM_CTRL_RDBACK_EN
      rsp_err_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_q      <= sel_req;
            mem_addr_o <= sel_req.addr;
            drive_q    <= sel_req.wr;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          cnt_q    <= '0;
          mem_wr_o <= req_q.wr;
          mem_rd_o <= ~req_q.wr;
          state_q  <= StStrobe;
        end
        StStrobe: begin
          if (cnt_q == CntLast) begin
            mem_wr_o <= 1'b0;
            mem_rd_o <= 1'b0;
            state_q  <= StHold;
`ifdef MEM_CTRL_RDBACK_EN
            // Writes report only after their read-back completes.
            if (!req_q.wr) begin
              rsp_valid_o[req_q.owner] <= 1'b1;
              rsp_rdata_o              <= mem_data_io;
            end
`else
            rsp_valid_o[req_q.owner] <= 1'b1;
            rsp_rdata_o              <= req_q.wr ? '0 : mem_data_io;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          drive_q <= 1'b0;
`ifdef MEM_CTRL_RDBACK_EN
          state_q <= req_q.wr ? StRbSetup : StIdle;
`else
          state_q <= StIdle;
`endif
        end
`ifdef MEM_CTRL_RDBACK_EN
        StRbSetup: begin
          cnt_q    <= '0;
          mem_rd_o <= 1'b1;
          state_q  <= StRbStrobe;
        end
        StRbStrobe: begin
          if (cnt_q == CntLast) begin
            mem_rd_o                 <= 1'b0;
            rsp_valid_o[req_q.owner] <= 1'b1;
            rsp_err_q                <= (mem_data_io != req_q.wdata);
            state_q                  <= StRbHold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRbHold: begin
          state_q <= StIdle;
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl against a transaction-level model plus a memory device model.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;
  localparam int unsigned S  = 3;
`ifdef MEM_CTRL_RDBACK_EN
  localparam bit RdBack = 1'b1;
`else
  localparam bit RdBack = 1'b0;
`endif

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct {
    int            due;
    logic          owner;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [1:0]      req_wr = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            mem_wr;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  wire  [DW-1:0]   mem_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STROBE_CYC (S)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_wr_o    (mem_wr),
    .mem_rd_o    (mem_rd),
    .mem_addr_o  (mem_addr),
    .mem_data_io (mem_data)
  );

  // Asynchronous memory device; corrupt_en flips bit 0 of anything stored at 6'h10.
  logic [DW-1:0] dev_mem [64];
  logic          corrupt_en = 1'b0;
  assign mem_data = mem_rd ? dev_mem[mem_addr] : 'z;
  always @(negedge clk) begin
    if (mem_wr) begin
      dev_mem[mem_addr] <= mem_data ^ ((corrupt_en && mem_addr == 6'h10) ? 64'h1 : 64'h0);
    end
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_mem [64];
  int            m_busy = 0;
  logic          m_ptr = 1'b0;
  exp_t          exp_q[$];
  int            cyc = 0;
  op_t           cur;
  int            wr_run = 0;
  int            rd_run = 0;
  logic [1:0]    fire = 2'b00;
  logic [1:0]    grant_log[$];
  logic [DW-1:0] last_rdata = '0;
  op_t           rq[2][$];

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic [1:0] exp_rsp;
    logic       win;
    exp_t       e;
    int         lat;
    if (!rst_n) begin
      check_eq("rst_ready", 64'(req_ready), 64'(0));
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_strobes", 64'({mem_wr, mem_rd}), 64'(0));
      check_eq("rst_addr", 64'(mem_addr), 64'(0));
      check_eq("rst_rdata", rsp_rdata, 64'(0));
      check_eq("rst_err", 64'(rsp_err), 64'(0));
      m_busy = 0;
      m_ptr  = 1'b0;
      exp_q.delete();
      wr_run = 0;
      rd_run = 0;
      fire   = 2'b00;
    end else begin
      cyc++;
      exp_ready = 2'b00;
      win = 1'b0;
      if (m_busy == 0 && req_valid != 2'b00) begin
        win = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        exp_ready[win] = 1'b1;
      end
      check_eq("ready", 64'(req_ready), 64'(exp_ready));
      fire = req_valid & req_ready;
      if (fire != 2'b00) grant_log.push_back(fire);

      exp_rsp = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        exp_rsp[e.owner] = 1'b1;
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
        last_rdata = rsp_rdata;
      end
      check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));

      check_eq("rd_wr_overlap", 64'(mem_rd & mem_wr), 64'(0));
      if (mem_wr) begin
        check_eq("wr_bus", mem_data, cur.wdata);
        check_eq("wr_addr", 64'(mem_addr), 64'(cur.addr));
        wr_run++;
      end else if (wr_run != 0) begin
        check_eq("wr_pulse_len", 64'(wr_run), 64'(S));
        wr_run = 0;
      end
      if (mem_rd) begin
        check_eq("rd_bus", mem_data, dev_mem[mem_addr]);
        check_eq("rd_addr", 64'(mem_addr), 64'(cur.addr));
        rd_run++;
      end else if (rd_run != 0) begin
        check_eq("rd_pulse_len", 64'(rd_run), 64'(S));
        rd_run = 0;
      end

      if (exp_ready != 2'b00) begin
        cur.wr    = req_wr[win];
        cur.addr  = req_addr[32'(win)*AW +: AW];
        cur.wdata = req_wdata[32'(win)*DW +: DW];
        e.owner = win;
        if (cur.wr) begin
          m_mem[cur.addr] = cur.wdata ^ ((corrupt_en && cur.addr == 6'h10) ? 64'h1 : 64'h0);
          e.rdata = '0;
          e.err   = RdBack && corrupt_en && (cur.addr == 6'h10);
          lat     = RdBack ? 2 * (2 + S) : 2 + S;
        end else begin
          e.rdata = m_mem[cur.addr];
          e.err   = 1'b0;
          lat     = 2 + S;
        end
        e.due  = cyc + lat;
        m_busy = lat + 1;
        exp_q.push_back(e);
        m_ptr = ~win;
      end
      if (m_busy > 0) m_busy--;
    end
  end

  task automatic tick();
    op_t tmp;
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (fire[r] && rq[r].size() > 0) tmp = rq[r].pop_front();
      if (rq[r].size() > 0) begin
        req_valid[r]            = 1'b1;
        req_wr[r]               = rq[r][0].wr;
        req_addr[r*AW +: AW]    = rq[r][0].addr;
        req_wdata[r*DW +: DW]   = rq[r][0].wdata;
      end else begin
        req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.wr = wr;
    o.addr = a;
    o.wdata = d;
    rq[r].push_back(o);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rq[0].delete();
    rq[1].delete();
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0 || exp_q.size() > 0 || m_busy != 0) && n < 2000) begin
      tick();
      n++;
    end
    check_eq("drain_in_time", 64'(n < 2000), 64'(1));
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] data4;
    int n;
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = '0;
      m_mem[i]   = '0;
    end

    // Reset then idle
    apply_reset();
    repeat (3) tick();
    check_eq("idle_strobes", 64'({mem_wr, mem_rd}), 64'(0));
    check_eq("idle_addr", 64'(mem_addr), 64'(0));
    check_eq("idle_rsp", 64'(rsp_valid), 64'(0));

    // Write then read back through requester 0
    push(0, 1'b1, 6'h05, 64'hDEAD_BEEF_0123_4567);
    push(0, 1'b0, 6'h05, 64'h0);
    drain();
    check_eq("t2_rdata", last_rdata, 64'hDEAD_BEEF_0123_4567);

    // Both requesters contending
    apply_reset();
    grant_log.delete();
    push(0, 1'b0, 6'h00, 64'h1111);
    push(0, 1'b0, 6'h00, 64'h2222);
    push(1, 1'b0, 6'h3F, 64'h3333);
    push(1, 1'b0, 6'h3F, 64'h4444);
    tick();
    drain();
    check_eq("t3_grants", 64'(grant_log.size()), 64'(4));
    if (grant_log.size() == 4) begin
      check_eq("t3_g0", 64'(grant_log[0]), 64'(2'b01));
      check_eq("t3_g1", 64'(grant_log[1]), 64'(2'b10));
      check_eq("t3_g2", 64'(grant_log[2]), 64'(2'b01));
      check_eq("t3_g3", 64'(grant_log[3]), 64'(2'b10));
    end

    // Reset in the middle of a write strobe
    data4 = 64'hA5A5_0F0F_1234_8765;
    push(0, 1'b1, 6'h22, data4);
    n = 0;
    while (!mem_wr && n < 50) begin
      tick();
      n++;
    end
    check_eq("t4_strobe_seen", 64'(mem_wr), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check_eq("t4_wr_drop", 64'(mem_wr), 64'(0));
    check_eq("t4_rd_low", 64'(mem_rd), 64'(0));
    check_eq("t4_no_rsp", 64'(rsp_valid), 64'(0));
    rq[0].delete();
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 1'b1, 6'h22, data4);
    push(0, 1'b0, 6'h22, 64'h0);
    tick();
    drain();
    check_eq("t4_reserved", last_rdata, data4);

    // Random traffic from both requesters
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        n = int'($urandom_range(1));
        if (rq[n].size() < 3) begin
          push(n, 1'($urandom_range(1)), AW'($urandom_range(63)), {$urandom, $urandom});
        end
      end
      tick();
    end
    drain();

`ifdef MEM_CTRL_RDBACK_EN
    // Read-back error detection
    apply_reset();
    corrupt_en = 1'b1;
    push(0, 1'b1, 6'h10, 64'h0123_4567_89AB_CDEF);
    push(1, 1'b1, 6'h11, 64'hFEDC_BA98_7654_3210);
    push(0, 1'b1, 6'h12, 64'h5555_AAAA_5555_AAAA);
    tick();
    drain();
    corrupt_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
